// File: rtl/writeback_pkg.sv
// writeback_pkg: shared types, channel-index width and load-data extraction
// for writeback_arbiter and its per-channel FIFOs.
package writeback_pkg;

  localparam int XLEN    = 64;
  localparam int CHW_MIN = 1;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } msize_t;

  typedef struct packed {
    word_t      pc;
    word_t      result;
    word_t      rdata;
    logic       memread;
    msize_t     msize;
    logic       is_unsigned;
    logic       regwrite;
    logic [4:0] wa;
  } wb_req_t;

  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : CHW_MIN;
  endfunction

  // Low address bits below the access size are ignored (lane alignment).
  function automatic word_t load_extract(
    word_t      rdata,
    logic [2:0] lo,
    msize_t     sz,
    logic       uns
  );
    word_t sh;
    word_t res;
    sh  = '0;
    res = rdata;
    unique case (sz)
      BYTE: begin
        sh  = rdata >> {lo, 3'b000};
        res = {{56{sh[7] & ~uns}}, sh[7:0]};
      end
      HALF: begin
        sh  = rdata >> {lo[2:1], 4'b0000};
        res = {{48{sh[15] & ~uns}}, sh[15:0]};
      end
      WORD: begin
        sh  = rdata >> {lo[2], 5'b00000};
        res = {{32{sh[31] & ~uns}}, sh[31:0]};
      end
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: producer-side bundle of NCH writeback request lanes.
// master = producers (execute/memory back-ends), slave = writeback_arbiter.
interface writeback_arbiter_if #(
  parameter int NCH = 3
) ();
  import writeback_pkg::*;

  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [NCH*XLEN-1:0] in_pc;
  logic [NCH*XLEN-1:0] in_result;
  logic [NCH*XLEN-1:0] in_rdata;
  logic [NCH-1:0]      in_memread;
  logic [NCH*2-1:0]    in_msize;
  logic [NCH-1:0]      in_unsigned;
  logic [NCH-1:0]      in_regwrite;
  logic [NCH*5-1:0]    in_wa;

  modport master (
    output in_valid,
    output in_pc,
    output in_result,
    output in_rdata,
    output in_memread,
    output in_msize,
    output in_unsigned,
    output in_regwrite,
    output in_wa,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_pc,
    input  in_result,
    input  in_rdata,
    input  in_memread,
    input  in_msize,
    input  in_unsigned,
    input  in_regwrite,
    input  in_wa,
    output in_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: per-channel writeback request FIFO with wrap-bit pointers and
// a destination-register mask of every occupied slot.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  wb_req_t     wdata,
  input  logic        pop,
  output wb_req_t     rdata,
  output logic        empty,
  output logic        full,
  output logic [31:0] pend
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // A slot is live when its distance from the read index is below count.
  always_comb begin
    logic [AW-1:0] off;
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr[AW-1:0];
      if (({1'b0, off} < count) && mem[i].regwrite &&
          (mem[i].wa != 5'd0))
        pend[mem[i].wa] = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: NCH request FIFOs retired round-robin into a registered
// regfile write/commit port. `WBARB_PERF_EN adds stall/retire counters.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter  int NCH   = 3,
  parameter  int DEPTH = 4,
  localparam int CHW   = ch_width(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  writeback_arbiter_if.slave in_if,
  output logic               rf_valid,
  output logic [4:0]         rf_wa,
  output word_t              rf_wd,
  output logic               commit_valid,
  output logic [CHW-1:0]     commit_ch,
  output word_t              commit_pc,
  output logic [31:0]        pending
`ifdef WBARB_PERF_EN
  ,
  output logic [NCH*32-1:0]  perf_stall,
  output logic [31:0]        perf_retire
`endif
);

  wb_req_t        req   [NCH];
  wb_req_t        head  [NCH];
  logic [31:0]    fpend [NCH];
  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] rr;
  logic [CHW-1:0] gidx;
  logic           gvalid;
  wb_req_t        sel;
  word_t          sel_wd;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign req[c].pc          = in_if.in_pc[c*XLEN +: XLEN];
    assign req[c].result      = in_if.in_result[c*XLEN +: XLEN];
    assign req[c].rdata       = in_if.in_rdata[c*XLEN +: XLEN];
    assign req[c].memread     = in_if.in_memread[c];
    assign req[c].msize       = msize_t'(in_if.in_msize[c*2 +: 2]);
    assign req[c].is_unsigned = in_if.in_unsigned[c];
    assign req[c].regwrite    = in_if.in_regwrite[c];
    assign req[c].wa          = in_if.in_wa[c*5 +: 5];

    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_if.in_valid[c]),
      .wdata (req[c]),
      .pop   (grant[c]),
      .rdata (head[c]),
      .empty (empty[c]),
      .full  (full[c]),
      .pend  (fpend[c])
    );
  end

  assign in_if.in_ready = ~full;

  // First non-empty channel at or after the round-robin pointer wins.
  always_comb begin
    logic [CHW-1:0] idx;
    grant  = '0;
    gvalid = 1'b0;
    gidx   = '0;
    idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(rr) + k) % NCH);
      if (!gvalid && !empty[idx]) begin
        gvalid = 1'b1;
        gidx   = idx;
      end
    end
    if (gvalid) grant[gidx] = 1'b1;
  end

  assign sel    = head[gidx];
  assign sel_wd = sel.memread ?
                  load_extract(sel.rdata, sel.result[2:0],
                               sel.msize, sel.is_unsigned) :
                  sel.result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= '0;
    end else if (gvalid) begin
      rr <= (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_valid     <= 1'b0;
      rf_wa        <= '0;
      rf_wd        <= '0;
      commit_valid <= 1'b0;
      commit_ch    <= '0;
      commit_pc    <= '0;
    end else if (gvalid) begin
      rf_valid     <= sel.regwrite && (sel.wa != 5'd0);
      rf_wa        <= sel.wa;
      rf_wd        <= sel_wd;
      commit_valid <= 1'b1;
      commit_ch    <= gidx;
      commit_pc    <= sel.pc;
    end else begin
      rf_valid     <= 1'b0;
      commit_valid <= 1'b0;
    end
  end

  // rf_valid already implies regwrite with a non-zero destination.
  always_comb begin
    pending = rf_valid ? (32'd1 << rf_wa) : 32'd0;
    for (int c = 0; c < NCH; c++) pending |= fpend[c];
  end

`ifdef WBARB_PERF_EN
  logic [31:0] stall_cnt [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_perf
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stall_cnt[c] <= '0;
      end else if (in_if.in_valid[c] && full[c] &&
                   (stall_cnt[c] != 32'hFFFF_FFFF)) begin
        stall_cnt[c] <= stall_cnt[c] + 32'd1;
      end
    end
    assign perf_stall[c*32 +: 32] = stall_cnt[c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retire <= '0;
    end else if (commit_valid && (perf_retire != 32'hFFFF_FFFF)) begin
      perf_retire <= perf_retire + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter.
// Define WBARB_PERF_EN to also exercise the perf counters.
module tb_writeback_arbiter;
  import writeback_pkg::*;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;
  localparam int NPER  = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_valid;
  logic [4:0]  rf_wa;
  word_t       rf_wd;
  logic        commit_valid;
  logic [1:0]  commit_ch;
  word_t       commit_pc;
  logic [31:0] pending;
`ifdef WBARB_PERF_EN
  logic [NCH*32-1:0] perf_stall;
  logic [31:0]       perf_retire;
`endif

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.NCH(NCH)) wb_if ();

  writeback_arbiter #(
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (wb_if),
    .rf_valid     (rf_valid),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .commit_valid (commit_valid),
    .commit_ch    (commit_ch),
    .commit_pc    (commit_pc),
    .pending      (pending)
`ifdef WBARB_PERF_EN
    ,
    .perf_stall   (perf_stall),
    .perf_retire  (perf_retire)
`endif
  );

  word_t  ld_rdata [8] = '{64'h80FF_0000_0000_0000, 64'h80FF_0000_0000_0000,
                           64'h8877_6655_F433_2211, 64'h8877_6655_F433_2211,
                           64'h8877_6655_F433_2211, 64'h8877_6655_F433_2211,
                           64'h8877_6655_F433_2211, 64'h8877_6655_F433_2211};
  int     ld_lo    [8] = '{7, 7, 3, 6, 5, 1, 3, 2};
  msize_t ld_sz    [8] = '{BYTE, BYTE, HALF, HALF, WORD, WORD, DWORD, BYTE};
  logic   ld_uns   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  word_t  ld_exp   [8] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                           64'hFFFF_FFFF_FFFF_F433, 64'h0000_0000_0000_8877,
                           64'hFFFF_FFFF_8877_6655, 64'h0000_0000_F433_2211,
                           64'h8877_6655_F433_2211, 64'h0000_0000_0000_0033};

  task automatic drive(input int ch, input word_t pc, input word_t result,
                       input word_t rdata, input logic memread,
                       input msize_t sz, input logic uns,
                       input logic regwrite, input logic [4:0] wa);
    wb_if.in_valid[ch]               = 1'b1;
    wb_if.in_pc[ch*XLEN +: XLEN]     = pc;
    wb_if.in_result[ch*XLEN +: XLEN] = result;
    wb_if.in_rdata[ch*XLEN +: XLEN]  = rdata;
    wb_if.in_memread[ch]             = memread;
    wb_if.in_msize[ch*2 +: 2]        = sz;
    wb_if.in_unsigned[ch]            = uns;
    wb_if.in_regwrite[ch]            = regwrite;
    wb_if.in_wa[ch*5 +: 5]           = wa;
  endtask

  task automatic idle_all();
    wb_if.in_valid    = '0;
    wb_if.in_pc       = '0;
    wb_if.in_result   = '0;
    wb_if.in_rdata    = '0;
    wb_if.in_memread  = '0;
    wb_if.in_msize    = '0;
    wb_if.in_unsigned = '0;
    wb_if.in_regwrite = '0;
    wb_if.in_wa       = '0;
  endtask

  function automatic word_t rr_pc(int c, int n);
    return 64'h4000 + word_t'(c * 256 + n * 4);
  endfunction

  function automatic word_t rr_res(int c, int n);
    return 64'hA000 + word_t'(c * 16 + n);
  endfunction

  function automatic logic [4:0] rr_wa(int c, int n);
    return 5'(1 + c * 8 + n % 7);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    #12;
    assertions++;
    if (commit_valid !== 1'b0 || rf_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids: got cv=%b rv=%b expected 0 0",
               commit_valid, rf_valid);
    end
    assertions++;
    if (rf_wa !== 5'd0 || rf_wd !== 64'd0 || commit_pc !== 64'd0 ||
        commit_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: got wa=%h wd=%h pc=%h ch=%h expected 0",
               rf_wa, rf_wd, commit_pc, commit_ch);
    end
    assertions++;
    if (pending !== 32'd0) begin
      failures++;
      $display("FAIL reset_pending: got %h expected 0", pending);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    assertions++;
    if (wb_if.in_ready !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 111", wb_if.in_ready);
    end
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(0, 64'h100, 64'h1234, 64'h0, 1'b0, DWORD, 1'b0, 1'b1, 5'd5);
    @(negedge clk);
    idle_all();
    assertions++;
    if (commit_valid !== 1'b0 || pending !== 32'h0000_0020) begin
      failures++;
      $display("FAIL alu_queued: got cv=%b pend=%h expected 0 00000020",
               commit_valid, pending);
    end
    @(negedge clk);
    assertions++;
    if (commit_valid !== 1'b1 || rf_valid !== 1'b1 || rf_wa !== 5'd5 ||
        commit_ch !== 2'd0) begin
      failures++;
      $display("FAIL alu_commit: got cv=%b rv=%b wa=%0d ch=%0d expected 1 1 5 0",
               commit_valid, rf_valid, rf_wa, commit_ch);
    end
    assertions++;
    if (rf_wd !== 64'h1234 || commit_pc !== 64'h100 ||
        pending !== 32'h0000_0020) begin
      failures++;
      $display("FAIL alu_data: got wd=%h pc=%h pend=%h expected 1234 100 20",
               rf_wd, commit_pc, pending);
    end
    @(negedge clk);
    assertions++;
    if (commit_valid !== 1'b0 || rf_valid !== 1'b0 || pending !== 32'd0 ||
        rf_wd !== 64'h1234) begin
      failures++;
      $display("FAIL alu_after: got cv=%b rv=%b pend=%h wd=%h expected 0 0 0 1234",
               commit_valid, rf_valid, pending, rf_wd);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 64'h2000 + word_t'(i * 4), 64'h9000 + word_t'(ld_lo[i]),
            ld_rdata[i], 1'b1, ld_sz[i], ld_uns[i], 1'b1, 5'(10 + i));
      @(negedge clk);
      idle_all();
      @(negedge clk);
      assertions++;
      if (commit_valid !== 1'b1 || rf_valid !== 1'b1 ||
          rf_wa !== 5'(10 + i) || commit_ch !== 2'd1) begin
        failures++;
        $display("FAIL load_%0d_ctl: got cv=%b rv=%b wa=%0d ch=%0d expected 1 1 %0d 1",
                 i, commit_valid, rf_valid, rf_wa, commit_ch, 10 + i);
      end
      assertions++;
      if (rf_wd !== ld_exp[i]) begin
        failures++;
        $display("FAIL load_%0d_data: got %h expected %h",
                 i, rf_wd, ld_exp[i]);
      end
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive(2, 64'h3000, 64'h55, 64'h0, 1'b0, DWORD, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    idle_all();
    assertions++;
    if (pending !== 32'd0) begin
      failures++;
      $display("FAIL x0_queued_pending: got %h expected 0", pending);
    end
    @(negedge clk);
    assertions++;
    if (commit_valid !== 1'b1 || rf_valid !== 1'b0 || commit_ch !== 2'd2 ||
        commit_pc !== 64'h3000 || rf_wd !== 64'h55 || pending !== 32'd0) begin
      failures++;
      $display("FAIL x0_commit: got cv=%b rv=%b ch=%0d pc=%h wd=%h pend=%h expected 1 0 2 3000 55 0",
               commit_valid, rf_valid, commit_ch, commit_pc, rf_wd, pending);
    end
    @(negedge clk);
    assertions++;
    if (commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL x0_after: got cv=%b expected 0", commit_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   sent [NCH];
    int   rcvd [NCH];
    int   occ  [NCH];
    logic vld  [NCH];
    logic [NCH-1:0] rdy_prev;
    int   ncommit;
    int   exp_ch;
    int   c;
    bit   saw_full;
    ncommit  = 0;
    exp_ch   = 0;
    saw_full = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sent[k] = 0;
      rcvd[k] = 0;
      occ[k]  = 0;
      vld[k]  = 1'b0;
    end
    idle_all();
    rdy_prev = wb_if.in_ready;
    for (int cyc = 0; cyc < 100 && ncommit < NCH * NPER; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
        if (vld[k] && rdy_prev[k]) begin
          sent[k]++;
          occ[k]++;
        end
      end
      if (commit_valid === 1'b1) begin
        c = int'(commit_ch);
        assertions++;
        if (c !== exp_ch) begin
          failures++;
          $display("FAIL rr_order: got ch %0d expected %0d", c, exp_ch);
        end
        if (c < NCH) begin
          assertions++;
          if (rcvd[c] >= NPER || commit_pc !== rr_pc(c, rcvd[c]) ||
              rf_wd !== rr_res(c, rcvd[c]) || rf_wa !== rr_wa(c, rcvd[c])) begin
            failures++;
            $display("FAIL rr_data ch%0d #%0d: got pc=%h wd=%h wa=%0d expected %h %h %0d",
                     c, rcvd[c], commit_pc, rf_wd, rf_wa, rr_pc(c, rcvd[c]),
                     rr_res(c, rcvd[c]), rr_wa(c, rcvd[c]));
          end
          rcvd[c]++;
          occ[c]--;
        end
        ncommit++;
        exp_ch = (exp_ch + 1) % NCH;
      end
      for (int k = 0; k < NCH; k++) begin
        assertions++;
        if (wb_if.in_ready[k] !== (occ[k] != DEPTH)) begin
          failures++;
          $display("FAIL rr_ready ch%0d: got %b expected %b (occupancy %0d)",
                   k, wb_if.in_ready[k], occ[k] != DEPTH, occ[k]);
        end
        if (occ[k] == DEPTH) saw_full = 1'b1;
        if (sent[k] < NPER) begin
          vld[k] = 1'b1;
          drive(k, rr_pc(k, sent[k]), rr_res(k, sent[k]), 64'h0, 1'b0,
                DWORD, 1'b0, 1'b1, rr_wa(k, sent[k]));
        end else begin
          vld[k] = 1'b0;
          wb_if.in_valid[k] = 1'b0;
        end
      end
      rdy_prev = wb_if.in_ready;
    end
    idle_all();
    assertions++;
    if (ncommit != NCH * NPER || rcvd[0] != NPER || rcvd[1] != NPER ||
        rcvd[2] != NPER) begin
      failures++;
      $display("FAIL rr_count: got %0d (%0d/%0d/%0d) expected %0d",
               ncommit, rcvd[0], rcvd[1], rcvd[2], NCH * NPER);
    end
    assertions++;
    if (!saw_full) begin
      failures++;
      $display("FAIL rr_backpressure: got no full FIFO expected at least one");
    end
  endtask

  task automatic test_reset_mid();
    idle_all();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        drive(k, 64'h5000 + word_t'(i * 4), 64'hB0 + word_t'(i), 64'h0,
              1'b0, DWORD, 1'b0, 1'b1, 5'(20 + k));
    end
    @(negedge clk);
    assertions++;
    if (wb_if.in_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: got in_ready[2]=%b expected 0",
               wb_if.in_ready[2]);
    end
    #2;
    reset = 1'b1;
    idle_all();
    #1;
    assertions++;
    if (commit_valid !== 1'b0 || rf_valid !== 1'b0 || rf_wa !== 5'd0 ||
        rf_wd !== 64'd0 || commit_pc !== 64'd0 || commit_ch !== 2'd0 ||
        pending !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got cv=%b rv=%b wa=%h wd=%h pc=%h ch=%h pend=%h expected all 0",
               commit_valid, rf_valid, rf_wa, rf_wd, commit_pc, commit_ch,
               pending);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    assertions++;
    if (wb_if.in_ready !== 3'b111) begin
      failures++;
      $display("FAIL mid_ready: got %b expected 111", wb_if.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      assertions++;
      if (commit_valid !== 1'b0 || pending !== 32'd0) begin
        failures++;
        $display("FAIL mid_stale: got cv=%b pend=%h expected 0 0",
                 commit_valid, pending);
      end
    end
  endtask

`ifdef WBARB_PERF_EN
  task automatic test_perf();
    int   stalls [NCH];
    int   sent   [NCH];
    logic vld    [NCH];
    logic [NCH-1:0] rdy_prev;
    int   retires;
    retires = 0;
    for (int k = 0; k < NCH; k++) begin
      stalls[k] = 0;
      sent[k]   = 0;
      vld[k]    = 1'b0;
    end
    assertions++;
    if (perf_stall !== '0 || perf_retire !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: got stall=%h retire=%0d expected 0 0",
               perf_stall, perf_retire);
    end
    idle_all();
    rdy_prev = wb_if.in_ready;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (commit_valid === 1'b1) retires++;
      for (int k = 0; k < NCH; k++) begin
        if (vld[k] && rdy_prev[k]) sent[k]++;
        vld[k] = 1'b1;
        drive(k, 64'h6000 + word_t'(sent[k]), 64'h1, 64'h0, 1'b0, DWORD,
              1'b0, 1'b1, 5'(k + 1));
        if (!wb_if.in_ready[k]) stalls[k]++;
      end
      rdy_prev = wb_if.in_ready;
    end
    @(negedge clk);
    if (commit_valid === 1'b1) retires++;
    idle_all();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (commit_valid === 1'b1) retires++;
    end
    for (int k = 0; k < NCH; k++) begin
      assertions++;
      if (perf_stall[k*32 +: 32] !== 32'(stalls[k])) begin
        failures++;
        $display("FAIL perf_stall ch%0d: got %0d expected %0d",
                 k, perf_stall[k*32 +: 32], stalls[k]);
      end
    end
    assertions++;
    if (perf_retire !== 32'(retires)) begin
      failures++;
      $display("FAIL perf_retire: got %0d expected %0d",
               perf_retire, retires);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0();
    test_back_to_back();
    test_reset_mid();
`ifdef WBARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Multi-channel successor to the single-lane writeback stage. NCH producer channels (e.g. ALU, load, mul/div) each push completed instructions into a private FIFO. A round-robin arbiter retires one entry per cycle into a registered regfile write port, performing load-data extraction on the way. Outputs also drive forwarding, the hazard unit and the commit/debug trace; the block sits between the memory/execute back-ends and the regfile.

Parameters:
NCH, 3, number of producer channels (1..8)
DEPTH, 4, entries per channel FIFO (power of two, >=2)
XLEN, 64, datapath width (fixed by word_t)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  NCH  channel c request valid
in_ready  out  NCH  channel c can accept (FIFO not full)
in_pc  in  NCH*XLEN  instruction pc (debug/commit)
in_result  in  NCH*XLEN  ALU result, or load address for loads
in_rdata  in  NCH*XLEN  raw 64-bit memory read word (loads only)
in_memread  in  NCH  entry is a load; select extracted rdata
in_msize  in  NCH*2  0=byte 1=half 2=word 3=dword
in_unsigned  in  NCH  zero-extend instead of sign-extend
in_regwrite  in  NCH  entry writes a GPR
in_wa  in  NCH*5  destination register
rf_valid  out  1  regfile write enable
rf_wa  out  5  regfile write address
rf_wd  out  XLEN  regfile write data (also forward/hazard data)
commit_valid  out  1  one instruction retired this cycle
commit_ch  out  $clog2(NCH) (min 1)  channel that retired
commit_pc  out  XLEN  pc of retired instruction
pending  out  32  bit r set if any queued or output-stage entry writes r

Behaviour:
- Reset (async): all FIFOs empty, rr pointer=0, rf_valid=0, rf_wa=0, rf_wd=0, commit_valid=0, commit_ch=0, commit_pc=0; pending=0, in_ready=all ones once reset deasserts.
- Push: channel c accepts when in_valid[c]&in_ready[c]; in_ready[c]=!full[c] (no same-cycle pass-through when full, even if popping).
- Arbitration (combinational each cycle): scan non-empty FIFOs starting at rr pointer; first found is granted and popped. rr pointer <= grant+1 mod NCH on grant; unchanged with no grant.
- Output stage: registered. Accept at edge t -> entry in FIFO -> granted earliest in the following cycle -> commit_valid/rf_* visible one cycle later. Minimum latency in_valid-cycle to commit_valid = 2 cycles. Throughput 1 retire/cycle aggregate.
- No grant: commit_valid=0, rf_valid=0; rf_wa/rf_wd/commit_pc hold previous values.
- rf_valid = regwrite && wa!=0; x0 writes retire (commit_valid=1) with rf_valid=0.
- Load extraction: lane offset = in_result[2:0] masked to size alignment (byte: [2:0], half: [2:1], word: [2], dword: none); selected field sign- or zero-extended per in_unsigned. Non-load: rf_wd=in_result.
- Ordering: FIFO order within a channel; no ordering across channels. WAW/RAW across channels is resolved upstream using pending.
- pending: OR of one-hot(wa) over all valid FIFO entries plus the output register, regwrite=1 and wa!=0 only; combinational from state.
- Simultaneous push and pop on the same non-full FIFO: both occur; count unchanged.
- Wrap-around: read/write pointers are $clog2(DEPTH)+1 bits; full = MSB differs and index bits equal.

Optional Feature:
WBARB_PERF_EN: when defined, adds output perf_stall (NCH*32): per-channel saturating counters incremented on each cycle in which in_valid[c]&!in_ready[c]; these counters reset to 0. Also adds perf_retire (32): saturating count of commit_valid cycles. When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- writeback_pkg: msize_t (2-bit enum BYTE/HALF/WORD/DWORD), wb_req_t struct {pc, result, rdata, memread, msize, unsigned, regwrite, wa}, channel-index width localparam.
- Sub-module wb_fifo (parametrised DEPTH, payload wb_req_t) instantiated NCH times; extraction is a function in the package.

Test Plan:
- Single ALU op ch0, wa=5, result=0x1234 -> two cycles later rf_valid=1, rf_wa=5, rf_wd=0x1234, commit_ch=0; pending[5] high meanwhile, then clear.
- Load ch1, rdata=0x80FF_0000_0000_0000, addr_lo=7, msize=BYTE, signed -> rf_wd=0xFFFF_FFFF_FFFF_FF80; same with unsigned -> 0x80.
- All 3 channels push every cycle for 12 cycles -> commit_ch sequence 0,1,2,0,1,2...; in_ready deasserts when a FIFO holds 4; no entry lost or duplicated, per-channel order preserved.
- wa=0 regwrite=1 -> commit_valid=1, rf_valid=0, pending unchanged.
- Fill ch2 to DEPTH, assert reset mid-burst -> all outputs 0 immediately, in_ready all ones after release, no stale commit afterwards.
- WBARB_PERF_EN defined: hold ch0 valid with FIFO full 10 cycles -> perf_stall[ch0]=10.
